// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: binary state register with registered binary,
// Gray and terminal-count outputs, plus enable, direction, parallel load and optional saturation.
module gray_counter_n #(
  parameter int unsigned WIDTH     = 3,
  parameter bit          SATURATE  = 1'b0,
  parameter bit          LOAD_GRAY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_tc;
  logic             w_at_term;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    if (LOAD_GRAY) begin : g_gray_load
      always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
          w_load_bin[i] = ^(load_val >> i);
        end
      end
    end else begin : g_bin_load
      assign w_load_bin = load_val;
    end
  endgenerate

  assign w_at_term = up ? (&r_bin) : ~(|r_bin);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_bin = r_bin;
    w_next_tc  = 1'b0;
    if (load) begin
      w_next_bin = w_load_bin;
    end else if (en) begin
      w_next_tc = w_at_term;
      if (!(SATURATE && w_at_term)) begin
        w_next_bin = up ? (r_bin + ONE) : (r_bin - ONE);
      end
    end
  end

  // Gray is computed from the next binary value so both outputs land on the same edge.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  // NOTE: state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_tc   <= w_next_tc;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign tc       = r_tc;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed and model-checked bench for gray_counter_n across wrap, Gray-load,
// saturating and 8-bit configurations.
module tb_gray_counter_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [2:0] load_val = '0;
  logic       en8 = 1'b0, up8 = 1'b1, load8 = 1'b0;
  logic [7:0] lv8 = '0;

  logic [2:0] a_bin, a_gray, g_bin, g_gray, s_bin, s_gray;
  logic       a_tc, g_tc, s_tc;
  logic [7:0] w_bin, w_gray;
  logic       w_tc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0), .LOAD_GRAY(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_out(a_bin), .gray_out(a_gray), .tc(a_tc));

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0), .LOAD_GRAY(1'b1)) dut_g (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_out(g_bin), .gray_out(g_gray), .tc(g_tc));

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b1), .LOAD_GRAY(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc));

  gray_counter_n #(.WIDTH(8), .SATURATE(1'b0), .LOAD_GRAY(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en(en8), .up(up8), .load(load8), .load_val(lv8),
    .bin_out(w_bin), .gray_out(w_gray), .tc(w_tc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; up = 1'b1;
    #2;
    if ({a_bin, a_gray, a_tc} !== 7'd0) begin n_fail++; $display("FAIL reset_a: got %b want 0", {a_bin, a_gray, a_tc}); end
    n_checks++;
    if ({s_bin, s_gray, s_tc, g_bin, g_gray, g_tc} !== 14'd0) begin n_fail++; $display("FAIL reset_sg: got %b want 0", {s_bin, s_gray, s_tc, g_bin, g_gray, g_tc}); end
    n_checks++;
    tick();
    tick();
    if ({a_bin, a_gray, a_tc, w_bin, w_gray, w_tc} !== 24'd0) begin n_fail++; $display("FAIL reset_held: got %h want 0", {a_bin, a_gray, a_tc, w_bin, w_gray, w_tc}); end
    n_checks++;
    en = 1'b0;
  endtask

  task automatic test_count_up();
    logic [2:0] exp_bin  [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [2:0] exp_gray [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    logic [2:0] prev;
    en = 1'b0; up = 1'b1; load = 1'b0;
    do_reset();
    tick();
    prev = a_gray;
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (a_bin !== exp_bin[k]) begin n_fail++; $display("FAIL up_bin[%0d]: got %0d want %0d", k, a_bin, exp_bin[k]); end
      n_checks++;
      if (a_gray !== exp_gray[k]) begin n_fail++; $display("FAIL up_gray[%0d]: got %b want %b", k, a_gray, exp_gray[k]); end
      n_checks++;
      if (a_tc !== (k == 7)) begin n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", k, a_tc, (k == 7)); end
      n_checks++;
      if ($countones(a_gray ^ prev) != 1) begin n_fail++; $display("FAIL up_hamming[%0d]: got %0d bits want 1", k, $countones(a_gray ^ prev)); end
      n_checks++;
      prev = a_gray;
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    en = 1'b0; up = 1'b0; load = 1'b0;
    do_reset();
    en = 1'b1;
    tick();
    if ({a_bin, a_gray, a_tc} !== {3'd7, 3'b100, 1'b1}) begin n_fail++; $display("FAIL down_wrap: got %b want %b", {a_bin, a_gray, a_tc}, {3'd7, 3'b100, 1'b1}); end
    n_checks++;
    if ({s_bin, s_tc} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL down_sat0: got %b want %b", {s_bin, s_tc}, {3'd0, 1'b1}); end
    n_checks++;
    tick();
    if ({a_bin, a_gray, a_tc} !== {3'd6, 3'b101, 1'b0}) begin n_fail++; $display("FAIL down_step: got %b want %b", {a_bin, a_gray, a_tc}, {3'd6, 3'b101, 1'b0}); end
    n_checks++;
    if ({s_bin, s_gray, s_tc} !== {3'd0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL down_sat_hold: got %b want %b", {s_bin, s_gray, s_tc}, {3'd0, 3'd0, 1'b1}); end
    n_checks++;
    en = 1'b0;
    tick();
    if ({a_bin, a_tc, s_tc} !== {3'd6, 1'b0, 1'b0}) begin n_fail++; $display("FAIL down_idle: got %b want %b", {a_bin, a_tc, s_tc}, {3'd6, 1'b0, 1'b0}); end
    n_checks++;
  endtask

  task automatic test_load();
    en = 1'b0; up = 1'b0; load = 1'b0;
    do_reset();
    en = 1'b1;
    tick();
    // a_tc is 1 here, so the load below must also clear it.
    load = 1'b1; load_val = 3'b101;
    tick();
    if ({a_bin, a_gray, a_tc} !== {3'd5, 3'b111, 1'b0}) begin n_fail++; $display("FAIL load_en_bin: got %b want %b", {a_bin, a_gray, a_tc}, {3'd5, 3'b111, 1'b0}); end
    n_checks++;
    if ({g_bin, g_gray, g_tc} !== {3'd6, 3'b101, 1'b0}) begin n_fail++; $display("FAIL load_en_gray: got %b want %b", {g_bin, g_gray, g_tc}, {3'd6, 3'b101, 1'b0}); end
    n_checks++;
    load = 1'b0; load_val = 3'b000;
    tick();
    load = 1'b1; en = 1'b0; load_val = 3'b101;
    tick();
    if ({a_bin, a_gray, a_tc} !== {3'd5, 3'b111, 1'b0}) begin n_fail++; $display("FAIL load_bin: got %b want %b", {a_bin, a_gray, a_tc}, {3'd5, 3'b111, 1'b0}); end
    n_checks++;
    if ({g_bin, g_gray, g_tc} !== {3'd6, 3'b101, 1'b0}) begin n_fail++; $display("FAIL load_gray: got %b want %b", {g_bin, g_gray, g_tc}, {3'd6, 3'b101, 1'b0}); end
    n_checks++;
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    if ({a_bin, g_bin} !== {3'd6, 3'd7}) begin n_fail++; $display("FAIL load_resume: got %b want %b", {a_bin, g_bin}, {3'd6, 3'd7}); end
    n_checks++;
    en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [2:0] exp_bin [5] = '{3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
    logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 3'd5;
    tick();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({s_bin, s_tc} !== {exp_bin[k], exp_tc[k]}) begin n_fail++; $display("FAIL sat_up[%0d]: got %0d/%b want %0d/%b", k, s_bin, s_tc, exp_bin[k], exp_tc[k]); end
      n_checks++;
    end
    if (s_gray !== 3'b100) begin n_fail++; $display("FAIL sat_gray: got %b want 100", s_gray); end
    n_checks++;
    up = 1'b0;
    tick();
    if ({s_bin, s_gray, s_tc} !== {3'd6, 3'b101, 1'b0}) begin n_fail++; $display("FAIL sat_reverse: got %b want %b", {s_bin, s_gray, s_tc}, {3'd6, 3'b101, 1'b0}); end
    n_checks++;
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    time t_edge;
    en = 1'b0; up = 1'b1; load = 1'b0;
    do_reset();
    en = 1'b1;
    repeat (4) tick();
    if (a_bin !== 3'd4) begin n_fail++; $display("FAIL async_pre: got %0d want 4", a_bin); end
    n_checks++;
    t_edge = $time;
    #2;
    reset = 1'b1;
    #1;
    if ({a_bin, a_gray, a_tc} !== 7'd0) begin n_fail++; $display("FAIL async_clear: got %b want 0", {a_bin, a_gray, a_tc}); end
    n_checks++;
    if ($time - t_edge >= 9) begin n_fail++; $display("FAIL async_timing: got %0t after edge want < 9", $time - t_edge); end
    n_checks++;
    #2;
    reset = 1'b0;
    tick();
    if ({a_bin, a_gray, a_tc} !== {3'd1, 3'b001, 1'b0}) begin n_fail++; $display("FAIL async_resume: got %b want %b", {a_bin, a_gray, a_tc}, {3'd1, 3'b001, 1'b0}); end
    n_checks++;
    en = 1'b0;
  endtask

  task automatic test_random_w8();
    logic [7:0] m_bin, prev_gray;
    logic       m_tc;
    int         bad = 0;
    en8 = 1'b0; load8 = 1'b0;
    do_reset();
    m_bin = '0; m_tc = 1'b0;
    tick();
    for (int k = 0; k < 1500; k++) begin
      prev_gray = w_gray;
      load8 = ($urandom_range(0, 7) == 0);
      en8   = ($urandom_range(0, 3) != 0);
      up8   = $urandom_range(0, 1) == 1;
      lv8   = 8'($urandom_range(0, 255));
      if (load8) begin
        m_bin = lv8; m_tc = 1'b0;
      end else if (en8) begin
        if (up8) begin m_tc = (m_bin == 8'hFF); m_bin = (m_bin == 8'hFF) ? 8'h00 : m_bin + 8'd1; end
        else     begin m_tc = (m_bin == 8'h00); m_bin = (m_bin == 8'h00) ? 8'hFF : m_bin - 8'd1; end
      end else begin
        m_tc = 1'b0;
      end
      tick();
      if ({w_bin, w_tc} !== {m_bin, m_tc}) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rnd_model[%0d]: got %h/%b want %h/%b", k, w_bin, w_tc, m_bin, m_tc);
      end
      n_checks++;
      if (w_gray !== (m_bin ^ (m_bin >> 1))) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rnd_gray[%0d]: got %h want %h", k, w_gray, m_bin ^ (m_bin >> 1));
      end
      n_checks++;
      if (!load8 && ($countones(w_gray ^ prev_gray) != (en8 ? 1 : 0))) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rnd_hamming[%0d]: got %0d bits want %0d", k, $countones(w_gray ^ prev_gray), en8 ? 1 : 0);
      end
      n_checks++;
    end
    en8 = 1'b0; load8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_saturate();
    test_async_reset();
    test_random_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
